// File: rtl/dac_serial_receiver.sv
// rtl/dac_serial_receiver.sv - serial DAC link receiver with frame deframing and DAC code latch
//
// Oversamples the DAC serial lines on fpgaClock, deframes MSB-first words of
// FRAME_BITS bits (control field followed by DATA_BITS data bits) and holds
// the latched DAC code.
// Optional feature: define DAC_RX_LDAC_EN to make dacValue load on the ldac
// falling edge instead of directly on frame acceptance.
//
// Ports:
//   fpgaClock      system clock (the only clock)
//   resetN         asynchronous active-low reset
//   dacSerialClock serial clock from transmitter (async)
//   syncDAC        frame select, active low (async)
//   dacDataIn      serial data (async)
//   ldac           load-DAC strobe, active low (async)
//   dacValue       DAC output register
//   dacCtrl        control field of the last accepted frame
//   frameValid     one-cycle pulse on an accepted frame
//   frameError     one-cycle pulse on a short or overrun frame
`timescale 1ns/1ps

module dac_serial_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            fpgaClock,
  input  logic                            resetN,
  input  logic                            dacSerialClock,
  input  logic                            syncDAC,
  input  logic                            dacDataIn,
  input  logic                            ldac,
  output logic [DATA_BITS-1:0]            dacValue,
  output logic [FRAME_BITS-DATA_BITS-1:0] dacCtrl,
  output logic                            frameValid,
  output logic                            frameError
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

  state_t state, next_state;

  // Synchronizer chains reset to 0 so that a line held low across reset
  // (e.g. syncDAC mid-frame) never produces a spurious falling edge.
  logic [SYNC_STAGES-1:0] sclk_sr, sync_sr, data_sr;
  logic                   sclk_q, sync_q;
  logic                   sclk_s, sync_s, data_s;
  logic                   sclk_fall, sync_fall, sync_rise;

  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0]  in_reg;

  always_ff @(posedge fpgaClock or negedge resetN) begin
    if (!resetN) begin
      sclk_sr <= '0;
      sync_sr <= '0;
      data_sr <= '0;
      sclk_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], dacSerialClock};
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], syncDAC};
      data_sr <= {data_sr[SYNC_STAGES-2:0], dacDataIn};
      sclk_q  <= sclk_s;
      sync_q  <= sync_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sync_s    = sync_sr[SYNC_STAGES-1];
  assign data_s    = data_sr[SYNC_STAGES-1];
  assign sclk_fall = sclk_q & ~sclk_s;
  assign sync_fall = sync_q & ~sync_s;
  assign sync_rise = ~sync_q & sync_s;

  always_ff @(posedge fpgaClock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ERR leaves once the synchronized select is high: for an abort that is
  // already true on entry, for an overrun it waits for the select to rise.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (sync_fall) next_state = SHIFT;
      SHIFT: begin
        if (sync_rise) begin
          next_state = (cnt == CNT_FULL) ? DONE : ERR;
        end else if (sclk_fall && (cnt >= CNT_FULL)) begin
          next_state = ERR;
        end
      end
      DONE:  next_state = IDLE;
      ERR:   if (sync_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge fpgaClock or negedge resetN) begin
    if (!resetN) begin
      cnt        <= '0;
      shift_reg  <= '0;
      in_reg     <= '0;
      dacCtrl    <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sync_fall) cnt <= '0;
        end
        SHIFT: begin
          // An sclk edge coinciding with the select rising is dropped.
          if (!sync_rise && sclk_fall) begin
            if (cnt < CNT_FULL) begin
              shift_reg <= {shift_reg[FRAME_BITS-2:0], data_s};
              cnt       <= cnt + CNT_W'(1);
            end else begin
              cnt <= CNT_OVER;
            end
          end
        end
        DONE: begin
          in_reg     <= shift_reg[DATA_BITS-1:0];
          dacCtrl    <= shift_reg[FRAME_BITS-1:DATA_BITS];
          frameValid <= 1'b1;
        end
        ERR: begin
          if (sync_s) frameError <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DAC_RX_LDAC_EN
  logic [SYNC_STAGES-1:0] ldac_sr;
  logic                   ldac_q;
  logic                   ldac_s;
  logic                   ldac_fall;

  always_ff @(posedge fpgaClock or negedge resetN) begin
    if (!resetN) begin
      ldac_sr <= '0;
      ldac_q  <= 1'b0;
    end else begin
      ldac_sr <= {ldac_sr[SYNC_STAGES-2:0], ldac};
      ldac_q  <= ldac_s;
    end
  end

  assign ldac_s    = ldac_sr[SYNC_STAGES-1];
  assign ldac_fall = ldac_q & ~ldac_s;

  // A load strobe landing in DONE takes the frame being accepted, not the
  // stale input register.
  always_ff @(posedge fpgaClock or negedge resetN) begin
    if (!resetN) begin
      dacValue <= '0;
    end else if (ldac_fall) begin
      dacValue <= (state == DONE) ? shift_reg[DATA_BITS-1:0] : in_reg;
    end
  end
`else
  logic unused_ldac;
  assign unused_ldac = ldac;
  assign dacValue    = in_reg;
`endif

endmodule

// File: tb/tb_dac_serial_receiver.sv
// tb/tb_dac_serial_receiver.sv - scoreboard testbench for dac_serial_receiver
`timescale 1ns/1ps

module tb_dac_serial_receiver;

  logic        fpgaClock = 1'b0;
  logic        resetN = 1'b0;
  logic        dacSerialClock = 1'b1;
  logic        syncDAC = 1'b1;
  logic        dacDataIn = 1'b0;
  logic        ldac = 1'b1;
  logic [11:0] dacValue;
  logic [3:0]  dacCtrl;
  logic        frameValid;
  logic        frameError;

  dac_serial_receiver #(
    .FRAME_BITS (16),
    .DATA_BITS  (12),
    .SYNC_STAGES(2)
  ) dut (
    .fpgaClock     (fpgaClock),
    .resetN        (resetN),
    .dacSerialClock(dacSerialClock),
    .syncDAC       (syncDAC),
    .dacDataIn     (dacDataIn),
    .ldac          (ldac),
    .dacValue      (dacValue),
    .dacCtrl       (dacCtrl),
    .frameValid    (frameValid),
    .frameError    (frameError)
  );

  always #5 fpgaClock = ~fpgaClock;

  typedef struct {
    bit          err;
    logic [3:0]  ctrl;
    logic [11:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  logic [3:0]  cur_ctrl = 4'h0;
  logic [11:0] cur_val  = 12'h000;
  logic [11:0] latest   = 12'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge fpgaClock);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input int nbits, input bit expect_err);
    exp_t e;
    if (expect_err) begin
      e = '{1'b1, cur_ctrl, cur_val};
    end else begin
      latest   = w[11:0];
      cur_ctrl = w[15:12];
`ifndef DAC_RX_LDAC_EN
      cur_val  = w[11:0];
`endif
      e = '{1'b0, cur_ctrl, cur_val};
    end
    exp_q.push_back(e);
    syncDAC = 1'b0;
    cyc(4);
    for (int i = 0; i < nbits; i++) begin
      dacSerialClock = 1'b1;
      dacDataIn = (i < 16) ? w[15-i] : 1'b0;
      cyc(2);
      dacSerialClock = 1'b0;
      cyc(2);
    end
    dacSerialClock = 1'b1;
    cyc(2);
    syncDAC = 1'b1;
    cyc(4);
  endtask

  task automatic pulse_ldac();
    ldac = 1'b0;
    cyc(4);
    ldac = 1'b1;
    cyc(6);
`ifdef DAC_RX_LDAC_EN
    cur_val = latest;
`endif
    check("dacValue_after_ldac", 32'(dacValue), 32'(cur_val));
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(negedge fpgaClock) begin
    if (resetN && (frameValid || frameError)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({frameValid, frameError}), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", 32'({frameValid, frameError}), e.err ? 32'd1 : 32'd2);
        check("pulse_dacCtrl", 32'(dacCtrl), 32'(e.ctrl));
        check("pulse_dacValue", 32'(dacValue), 32'(e.val));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    int          waited;

    // Reset with idle lines, then 100 quiet cycles.
    cyc(5);
    check("reset_dacValue", 32'(dacValue), 32'd0);
    check("reset_dacCtrl", 32'(dacCtrl), 32'd0);
    check("reset_pulses", 32'({frameValid, frameError}), 32'd0);
    resetN = 1'b1;
    cyc(100);
    check("idle_dacValue", 32'(dacValue), 32'd0);
    check("idle_dacCtrl", 32'(dacCtrl), 32'd0);

    // Good frame then load strobe.
    send(16'h3ABC, 16, 1'b0);
    pulse_ldac();
    check("f1_dacCtrl", 32'(dacCtrl), 32'h3);
    check("f1_dacValue", 32'(dacValue), 32'hABC);

    // Abort after 9 bits: outputs retained.
    send(16'h5555, 9, 1'b1);
    check("abort_dacCtrl", 32'(dacCtrl), 32'h3);
    check("abort_dacValue", 32'(dacValue), 32'hABC);

    // Overrun with 17 falling edges.
    send(16'h7123, 17, 1'b1);
    check("overrun_dacCtrl", 32'(dacCtrl), 32'h3);
    check("overrun_dacValue", 32'(dacValue), 32'hABC);

    // Reset mid-frame after 8 bits of 0x0FFF.
    w = 16'h0FFF;
    syncDAC = 1'b0;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      dacSerialClock = 1'b1;
      dacDataIn = w[15-i];
      cyc(2);
      dacSerialClock = 1'b0;
      cyc(2);
    end
    resetN = 1'b0;
    cyc(2);
    check("midreset_dacValue", 32'(dacValue), 32'd0);
    check("midreset_dacCtrl", 32'(dacCtrl), 32'd0);
    cur_ctrl = 4'h0;
    cur_val  = 12'h000;
    latest   = 12'h000;
    resetN = 1'b1;
    cyc(4);
    dacSerialClock = 1'b1;
    cyc(2);
    syncDAC = 1'b1;
    cyc(8);
    send(16'h1123, 16, 1'b0);
    pulse_ldac();
    check("after_reset_dacCtrl", 32'(dacCtrl), 32'h1);
    check("after_reset_dacValue", 32'(dacValue), 32'h123);

    // Back-to-back random frames at sclk = fpgaClock/4.
    for (int k = 0; k < 64; k++) begin
      w = 16'($urandom);
      send(w, 16, 1'b0);
    end
    pulse_ldac();
    check("rand_last_dacValue", 32'(dacValue), 32'(latest));

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      cyc(1);
      waited++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
